// File: rtl/chess_turn_ctrl_pkg.sv
// Shared types and constants for the chess turn controller: FSM states,
// turn/loser player codes and the default per-player time budget.
package chess_turn_ctrl_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    P1_RUN  = 2'd1,
    P2_RUN  = 2'd2,
    TIMEOUT = 2'd3
  } state_t;

  typedef logic [1:0] turn_t;

  localparam turn_t TURN_NONE = 2'b00;
  localparam turn_t TURN_P1   = 2'b01;
  localparam turn_t TURN_P2   = 2'b10;

  // Per-player budget in BCD {sec10, sec1, csec10, csec1}: 30.00 s
  localparam logic [15:0] INIT_TIME_DEF = 16'h3000;

endpackage

// File: rtl/chess_turn_ctrl_if.sv
// Control pulses in, turn/timer status out, between a game host (master)
// and the turn controller (slave).
interface chess_turn_ctrl_if;
  import chess_turn_ctrl_pkg::*;

  logic        start;
  logic        move_done;
  logic        abort;
  turn_t       turn;
  logic [15:0] time_bcd;
  logic        timeout;
  turn_t       loser;

  modport master (
    output start, move_done, abort,
    input  turn, time_bcd, timeout, loser
  );

  modport slave (
    input  start, move_done, abort,
    output turn, time_bcd, timeout, loser
  );

endinterface

// File: rtl/chess_turn_ctrl_bcd_dec4.sv
// 4-digit BCD decrement by one with borrow; saturates at 0000 and flags a
// zero result.
module bcd_dec4 (
  input  logic [15:0] i_val,
  output logic [15:0] o_dec,
  output logic        o_zero
);

  logic w_borrow;

  always_comb begin
    o_dec    = '0;
    w_borrow = 1'b1;
    for (int unsigned i = 0; i < 4; i++) begin
      if (w_borrow && (i_val[4*i +: 4] == 4'd0)) begin
        o_dec[4*i +: 4] = 4'd9;
      end else if (w_borrow) begin
        o_dec[4*i +: 4] = i_val[4*i +: 4] - 4'd1;
        w_borrow        = 1'b0;
      end else begin
        o_dec[4*i +: 4] = i_val[4*i +: 4];
      end
    end
    if (i_val == 16'h0000) o_dec = '0;
    o_zero = (o_dec == 16'h0000);
  end

endmodule

// File: rtl/chess_turn_ctrl.sv
// Two-player chess clock: alternates turns on move_done, counts down the
// active player's BCD budget every 10 ms and latches the loser on expiry.
module chess_turn_ctrl
  import chess_turn_ctrl_pkg::*;
#(
  parameter int unsigned TICK_DIV  = 250000,
  parameter logic [15:0] INIT_TIME = INIT_TIME_DEF
) (
  input  logic             segclk,
  input  logic             reset,
  chess_turn_ctrl_if.slave bus
);

  localparam int unsigned PW = $clog2(TICK_DIV);
  localparam logic [PW-1:0] PRESC_LAST = PW'(TICK_DIV - 1);

  state_t        r_state, w_state_nxt;
  logic [15:0]   r_b1, r_b2, w_b1_nxt, w_b2_nxt;
  logic [PW-1:0] r_presc, w_presc_nxt;
  turn_t         r_turn, w_turn_nxt, r_loser, w_loser_nxt;
  logic [15:0]   r_time, w_time_nxt;
  logic          r_timeout;

  logic        w_run, w_tick, w_zero;
  logic [15:0] w_active, w_dec;

  assign w_run    = (r_state == P1_RUN) || (r_state == P2_RUN);
  assign w_tick   = w_run && (r_presc == PRESC_LAST);
  assign w_active = (r_state == P2_RUN) ? r_b2 : r_b1;

  bcd_dec4 u_dec (
    .i_val  (w_active),
    .o_dec  (w_dec),
    .o_zero (w_zero)
  );

  always_comb begin
    w_state_nxt = r_state;
    w_b1_nxt    = r_b1;
    w_b2_nxt    = r_b2;
    w_presc_nxt = r_presc;
    w_loser_nxt = r_loser;

    unique case (r_state)
      IDLE: begin
        if (bus.start) begin
          w_b1_nxt    = INIT_TIME;
          w_b2_nxt    = INIT_TIME;
          w_presc_nxt = '0;
          w_state_nxt = P1_RUN;
        end
      end
      P1_RUN, P2_RUN: begin
        w_presc_nxt = w_tick ? '0 : r_presc + PW'(1);
        if (w_tick) begin
          if (r_state == P1_RUN) w_b1_nxt = w_dec;
          else                   w_b2_nxt = w_dec;
        end
        // The tick is applied before move_done, so an expiring tick wins.
        if (w_tick && w_zero) begin
          w_state_nxt = TIMEOUT;
          w_loser_nxt = (r_state == P1_RUN) ? TURN_P1 : TURN_P2;
        end else if (bus.move_done) begin
          w_state_nxt = (r_state == P1_RUN) ? P2_RUN : P1_RUN;
          w_presc_nxt = '0;
        end
      end
      TIMEOUT: ;
      default: w_state_nxt = IDLE;
    endcase

    if (bus.abort) begin
      w_state_nxt = IDLE;
      w_presc_nxt = '0;
      w_loser_nxt = TURN_NONE;
      w_b1_nxt    = r_b1;
      w_b2_nxt    = r_b2;
    end

    // Outputs are registered from next-state values so they track the state.
    unique case (w_state_nxt)
      P1_RUN:  begin w_turn_nxt = TURN_P1;     w_time_nxt = w_b1_nxt; end
      P2_RUN:  begin w_turn_nxt = TURN_P2;     w_time_nxt = w_b2_nxt; end
      TIMEOUT: begin w_turn_nxt = w_loser_nxt; w_time_nxt = '0;       end
      default: begin w_turn_nxt = TURN_NONE;   w_time_nxt = w_b1_nxt; end
    endcase
  end

  always_ff @(posedge segclk) begin
    if (reset) begin
      r_state   <= IDLE;
      r_presc   <= '0;
      r_b1      <= INIT_TIME;
      r_b2      <= INIT_TIME;
      r_turn    <= TURN_NONE;
      r_time    <= INIT_TIME;
      r_timeout <= 1'b0;
      r_loser   <= TURN_NONE;
    end else begin
      r_state   <= w_state_nxt;
      r_presc   <= w_presc_nxt;
      r_b1      <= w_b1_nxt;
      r_b2      <= w_b2_nxt;
      r_turn    <= w_turn_nxt;
      r_time    <= w_time_nxt;
      r_timeout <= (w_state_nxt == TIMEOUT);
      r_loser   <= w_loser_nxt;
    end
  end

  assign bus.turn     = r_turn;
  assign bus.time_bcd = r_time;
  assign bus.timeout  = r_timeout;
  assign bus.loser    = r_loser;

endmodule

// File: tb/tb_chess_turn_ctrl.sv
// Scoreboard bench for chess_turn_ctrl: directed pulses queue expected
// status per clock edge; a negedge monitor pops and compares.
module tb_chess_turn_ctrl;

  logic clk = 1'b0;
  logic rst;
  int   cyc = 0;
  int   n_cmp = 0;
  int   n_bad = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  chess_turn_ctrl_if bus_a ();
  chess_turn_ctrl_if bus_b ();

  chess_turn_ctrl #(.TICK_DIV(4), .INIT_TIME(16'h0003)) dut_a (
    .segclk (clk),
    .reset  (rst),
    .bus    (bus_a)
  );

  chess_turn_ctrl #(.TICK_DIV(4), .INIT_TIME(16'h0100)) dut_b (
    .segclk (clk),
    .reset  (rst),
    .bus    (bus_b)
  );

  typedef struct {
    int          due;
    int          sel;
    string       nm;
    logic [1:0]  turn;
    logic [15:0] tm;
    logic        to;
    logic [1:0]  lo;
  } exp_t;

  exp_t q[$];
  exp_t e;

  task automatic expect_at(input int due, input int sel, input string nm,
                           input logic [1:0] t, input logic [15:0] tm,
                           input logic to, input logic [1:0] lo);
    exp_t x;
    x.due = due; x.sel = sel; x.nm = nm;
    x.turn = t; x.tm = tm; x.to = to; x.lo = lo;
    q.push_back(x);
  endtask

  // Monitor: compare every queued expectation that falls due at this edge.
  always @(negedge clk) begin
    logic [1:0]  a_turn;
    logic [15:0] a_tm;
    logic        a_to;
    logic [1:0]  a_lo;
    while (q.size() > 0 && q[0].due <= cyc) begin
      e = q.pop_front();
      if (e.sel == 1) begin
        a_turn = bus_b.turn; a_tm = bus_b.time_bcd; a_to = bus_b.timeout; a_lo = bus_b.loser;
      end else begin
        a_turn = bus_a.turn; a_tm = bus_a.time_bcd; a_to = bus_a.timeout; a_lo = bus_a.loser;
      end
      n_cmp++;
      if (e.due != cyc || a_turn !== e.turn || a_tm !== e.tm || a_to !== e.to || a_lo !== e.lo) begin
        n_bad++;
        $display("FAIL %s @cyc %0d: got turn=%b time=%h timeout=%b loser=%b, want turn=%b time=%h timeout=%b loser=%b",
                 e.nm, cyc, a_turn, a_tm, a_to, a_lo, e.turn, e.tm, e.to, e.lo);
      end
    end
  end

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // which: 0 = start, 1 = move_done, 2 = abort
  task automatic pulse_a(input int which);
    if (which == 0) bus_a.start = 1'b1;
    if (which == 1) bus_a.move_done = 1'b1;
    if (which == 2) bus_a.abort = 1'b1;
    step(1);
    bus_a.start = 1'b0; bus_a.move_done = 1'b0; bus_a.abort = 1'b0;
  endtask

  task automatic pulse_reset();
    rst = 1'b1;
    step(1);
    rst = 1'b0;
  endtask

  initial begin
    #20000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int s;
    rst = 1'b1;
    bus_a.start = 1'b0; bus_a.move_done = 1'b0; bus_a.abort = 1'b0;
    bus_b.start = 1'b0; bus_b.move_done = 1'b0; bus_b.abort = 1'b0;
    step(2);
    rst = 1'b0;
    n_cmp++;
    if (bus_a.turn !== 2'b00 || bus_a.time_bcd !== 16'h0003) begin
      n_bad++;
      $display("FAIL direct_reset: turn=%b time=%h", bus_a.turn, bus_a.time_bcd);
    end
    expect_at(cyc, 0, "reset_a", 2'b00, 16'h0003, 1'b0, 2'b00);
    expect_at(cyc, 1, "reset_b", 2'b00, 16'h0100, 1'b0, 2'b00);

    // Start, first tick, turn switches, abort mid-P2, reset
    pulse_a(1);
    expect_at(cyc, 0, "idle_ignore_move", 2'b00, 16'h0003, 1'b0, 2'b00);
    pulse_a(0); s = cyc;
    expect_at(s,     0, "start",    2'b01, 16'h0003, 1'b0, 2'b00);
    expect_at(s + 3, 0, "pre_tick", 2'b01, 16'h0003, 1'b0, 2'b00);
    expect_at(s + 4, 0, "tick1",    2'b01, 16'h0002, 1'b0, 2'b00);
    step(4);
    pulse_a(1);
    expect_at(cyc, 0, "move_to_p2", 2'b10, 16'h0003, 1'b0, 2'b00);
    pulse_a(1);
    expect_at(cyc, 0, "move_to_p1", 2'b01, 16'h0002, 1'b0, 2'b00);
    pulse_a(1);
    expect_at(cyc, 0, "move_to_p2b", 2'b10, 16'h0003, 1'b0, 2'b00);
    pulse_a(2);
    expect_at(cyc, 0, "abort_p2", 2'b00, 16'h0002, 1'b0, 2'b00);
    step(2);
    expect_at(cyc, 0, "idle_keeps_budget", 2'b00, 16'h0002, 1'b0, 2'b00);
    pulse_reset();
    n_cmp++;
    if (bus_a.time_bcd !== 16'h0003) begin
      n_bad++;
      $display("FAIL direct_reset_restores: time=%h", bus_a.time_bcd);
    end
    expect_at(cyc, 0, "reset_restores", 2'b00, 16'h0003, 1'b0, 2'b00);

    // Player 1 expires without moving
    pulse_a(0); s = cyc;
    expect_at(s + 11, 0, "p1_last_csec", 2'b01, 16'h0001, 1'b0, 2'b00);
    expect_at(s + 12, 0, "p1_expire",    2'b01, 16'h0000, 1'b1, 2'b01);
    step(13);
    n_cmp++;
    if (bus_a.timeout !== 1'b1 || bus_a.loser !== 2'b01) begin
      n_bad++;
      $display("FAIL direct_expire: timeout=%b loser=%b", bus_a.timeout, bus_a.loser);
    end
    pulse_a(1);
    expect_at(cyc, 0, "timeout_ignore_move", 2'b01, 16'h0000, 1'b1, 2'b01);
    pulse_a(0);
    expect_at(cyc, 0, "timeout_ignore_start", 2'b01, 16'h0000, 1'b1, 2'b01);
    pulse_a(2);
    expect_at(cyc, 0, "abort_timeout", 2'b00, 16'h0000, 1'b0, 2'b00);
    pulse_reset();
    expect_at(cyc, 0, "reset_after_timeout", 2'b00, 16'h0003, 1'b0, 2'b00);

    // move_done on the same cycle as the expiring tick
    pulse_a(0); s = cyc;
    step(11);
    pulse_a(1);
    expect_at(cyc, 0, "tick_and_move", 2'b01, 16'h0000, 1'b1, 2'b01);
    step(1);
    expect_at(cyc, 0, "no_switch_p2", 2'b01, 16'h0000, 1'b1, 2'b01);
    pulse_reset();
    expect_at(cyc, 0, "reset_clean", 2'b00, 16'h0003, 1'b0, 2'b00);

    // Reset on a tick edge leaves no residual decrement
    pulse_a(0); s = cyc;
    step(3);
    pulse_reset();
    expect_at(cyc, 0, "reset_on_tick", 2'b00, 16'h0003, 1'b0, 2'b00);
    step(1);
    expect_at(cyc, 0, "post_reset_idle", 2'b00, 16'h0003, 1'b0, 2'b00);

    // abort beats a simultaneous start
    bus_a.start = 1'b1; bus_a.abort = 1'b1;
    step(1);
    bus_a.start = 1'b0; bus_a.abort = 1'b0;
    expect_at(cyc, 0, "abort_over_start", 2'b00, 16'h0003, 1'b0, 2'b00);

    // BCD borrow across digits on the 01.00 s instance
    bus_b.start = 1'b1;
    step(1);
    bus_b.start = 1'b0;
    s = cyc;
    expect_at(s,     1, "b_start",   2'b01, 16'h0100, 1'b0, 2'b00);
    expect_at(s + 4, 1, "b_borrow",  2'b01, 16'h0099, 1'b0, 2'b00);
    expect_at(s + 8, 1, "b_second",  2'b01, 16'h0098, 1'b0, 2'b00);
    step(9);
    n_cmp++;
    if (bus_b.time_bcd !== 16'h0098) begin
      n_bad++;
      $display("FAIL direct_b_second: time=%h", bus_b.time_bcd);
    end

    step(2);
    while (q.size() > 0) begin
      e = q.pop_front();
      n_cmp++;
      n_bad++;
      $display("FAIL %s: never checked, due cyc %0d", e.nm, e.due);
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/chess_turn_ctrl.md
CHESS_TURN_CTRL -- requirements
Module: chess_turn_ctrl

Interface
REQ-001 Parameter TICK_DIV, default 250000, gives segclk cycles per 10 ms tick; legal range is 2 or more.
REQ-002 Parameter INIT_TIME, default 16'h3000, is each player's BCD budget {sec10, sec1, csec10, csec1}, i.e. 30.00 s.
REQ-003 Port segclk, input, 1 bit: the single clock, 25 MHz.
REQ-004 Port reset, input, 1 bit: synchronous, active-high reset.
REQ-005 Port start, input, 1 bit: one-cycle pulse that begins a game with player 1 to move.
REQ-006 Port move_done, input, 1 bit: one-cycle pulse meaning the active player completed a move.
REQ-007 Port abort, input, 1 bit: one-cycle pulse that returns the block to IDLE.
REQ-008 Port turn, output, 2 bits: 00 = none, 01 = player 1, 10 = player 2; drives the timer display player field.
REQ-009 Port time_bcd, output, 16 bits: active player's remaining time in BCD.
REQ-010 Port timeout, output, 1 bit: high while in state TIMEOUT.
REQ-011 Port loser, output, 2 bits: player whose clock expired, same encoding as turn; 00 otherwise.

Function
REQ-012 The FSM SHALL have exactly the states IDLE, P1_RUN, P2_RUN and TIMEOUT.
REQ-013 IDLE: on start, both budgets load INIT_TIME, the prescaler clears, and the next state is P1_RUN; all other inputs are ignored.
REQ-014 P1_RUN: move_done moves to P2_RUN; P2_RUN: move_done moves to P1_RUN; the player who moved keeps the time remaining.
REQ-015 The prescaler SHALL count 0..TICK_DIV-1 only in P1_RUN and P2_RUN and emit an internal tick when it wraps to 0.
- It clears on every turn switch, so each turn starts with a full tick period.
REQ-016 On a tick, only the active player's budget SHALL decrement by 1 centisecond.
- The decrement is BCD with borrow through 4 digits; a digit below 0 wraps to 9.
REQ-017 A tick that makes the active budget 16'h0000 SHALL move the FSM to TIMEOUT on the next edge, with loser = active player.
REQ-018 If tick and move_done occur in the same cycle, the tick SHALL be applied first.
- If the tick reaches 0000, TIMEOUT wins and move_done is ignored.
- Otherwise the turn switches.
REQ-019 TIMEOUT holds its state until abort or reset; start and move_done are ignored; the budgets are frozen.
REQ-020 abort SHALL return the FSM to IDLE from any state within 1 cycle.
- turn, loser and timeout go to 0; budgets hold their values; abort has priority over all other inputs.
REQ-021 turn SHALL be registered and reflect the state: 01 in P1_RUN, 10 in P2_RUN, 00 in IDLE, and the loser's code in TIMEOUT.
REQ-022 time_bcd SHALL be registered and show the active player's budget one cycle after the budget update.
- In TIMEOUT it shows 0000; in IDLE it shows player 1's budget.
REQ-023 A start pulse outside IDLE SHALL have no effect.
REQ-024 Budgets SHALL never underflow below 0000.

Reset
REQ-025 On segclk with reset high, the following values SHALL take effect in the same edge, overriding all inputs:
- state = IDLE, prescaler = 0, both budgets = INIT_TIME;
- turn = 00, time_bcd = INIT_TIME, timeout = 0, loser = 00.
REQ-026 Reset asserted mid-game SHALL discard all game state with no residual tick or turn switch.

Structure
REQ-027 A shared package SHALL hold the turn/loser encodings (TURN_NONE, TURN_P1, TURN_P2), the state enumeration and the INIT_TIME default.
REQ-028 A single sub-module bcd_dec4 SHALL be used: a 4-digit combinational BCD decrement with a zero flag, instantiated once and muxed on the active player.
REQ-029 The prescaler width SHALL be clog2(TICK_DIV).

Verification (TICK_DIV = 4, INIT_TIME = 16'h0003 unless noted)
REQ-030 Reset then start: turn = 01 and time_bcd = 0003 next cycle; after 4 cycles time_bcd = 0002.
REQ-031 INIT_TIME = 16'h0100, run 1 tick: time_bcd = 0099, which checks BCD borrow across digits.
REQ-032 Pulse move_done after 1 tick:
- turn = 10 and time_bcd = 0003;
- a second move_done returns turn = 01 and time_bcd = 0002.
REQ-033 Let player 1 expire without moves: after 12 cycles timeout = 1, loser = 01, turn = 01, time_bcd = 0000; a later move_done changes nothing.
REQ-034 Assert move_done on the cycle of the tick that hits 0000: timeout = 1 and loser = 01, with no switch to player 2.
REQ-035 Assert abort and reset mid-P2_RUN:
- abort gives turn = 00 and timeout = 0 next cycle, and budgets are retained;
- reset restores both budgets to INIT_TIME.
